// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for the multicycle core.
// master = controller, slave = datapath side.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [3:0] alu_ctrl;
    logic       retire;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode,
        input  funct3,
        input  funct7b5,
        input  zero,
        input  mem_ready,
        output pc_write,
        output ir_write,
        output adr_src,
        output mem_write,
        output reg_write,
        output result_src,
        output alu_src_a,
        output alu_src_b,
        output imm_src,
        output alu_ctrl,
        output retire,
        output illegal,
        output state
    );

    modport slave (
        output opcode,
        output funct3,
        output funct7b5,
        output zero,
        output mem_ready,
        input  pc_write,
        input  ir_write,
        input  adr_src,
        input  mem_write,
        input  reg_write,
        input  result_src,
        input  alu_src_a,
        input  alu_src_b,
        input  imm_src,
        input  alu_ctrl,
        input  retire,
        input  illegal,
        input  state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main controller for the multicycle RV32 datapath.
// Sequences fetch/decode/execute over one shared memory port.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              reset_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t     state_q;
    state_t     state_n;

    logic       is_lw;
    logic       is_sw;
    logic       is_r;
    logic       is_i;
    logic       is_br;
    logic       is_jal;
    logic       br_ok;

    logic [3:0] alu_dec;
    logic       pc_write_c;
    logic       ir_write_c;
    logic       mem_write_c;
    logic       reg_write_c;
    logic       retire_c;
    logic       adr_src_c;
    logic [1:0] result_src_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [3:0] alu_ctrl_c;
    logic [1:0] imm_src_c;

    assign is_lw  = (bus.opcode == OP_LW);
    assign is_sw  = (bus.opcode == OP_SW);
    assign is_r   = (bus.opcode == OP_R);
    assign is_i   = (bus.opcode == OP_I);
    assign is_br  = (bus.opcode == OP_BR);
    assign is_jal = (bus.opcode == OP_JAL);
    assign br_ok  = is_br && (bus.funct3[2:1] == 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        imm_src_c = 2'b00;
        unique case (1'b1)
            is_sw:   imm_src_c = 2'b01;
            is_br:   imm_src_c = 2'b10;
            is_jal:  imm_src_c = 2'b11;
            default: imm_src_c = 2'b00;
        endcase
    end

    // SUB needs the R-type opcode; addi ignores bit 30.
    always_comb begin
        alu_dec = ALU_ADD;
        unique case (bus.funct3)
            3'b000:  alu_dec = (is_r && bus.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = bus.funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        state_n      = state_q;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        retire_c     = 1'b0;
        adr_src_c    = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_ctrl_c   = ALU_ADD;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b_c = 2'b10;
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
                state_n     = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                unique case (1'b1)
                    is_lw || is_sw: state_n = S_MEMADR;
                    is_r:           state_n = S_EXECR;
                    is_i:           state_n = S_EXECI;
                    br_ok:          state_n = S_BRANCH;
                    is_jal:         state_n = S_JAL;
                    default:        state_n = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_n     = is_lw ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                state_n   = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                state_n      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                retire_c    = bus.mem_ready;
                state_n     = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a_c = 2'b10;
                alu_ctrl_c  = alu_dec;
                state_n     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_ctrl_c  = alu_dec;
                state_n     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_n     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 2'b10;
                alu_ctrl_c  = ALU_SUB;
                pc_write_c  = bus.zero ^ bus.funct3[0];
                retire_c    = 1'b1;
                state_n     = S_FETCH;
            end
            S_JAL: begin
                // ALU forms PC+4 for the link write in ALUWB.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_n     = S_ALUWB;
            end
            S_TRAP: begin
                state_n = S_TRAP;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    // Strobes are gated so nothing commits while reset is held.
    assign bus.pc_write   = pc_write_c  & reset_n;
    assign bus.ir_write   = ir_write_c  & reset_n;
    assign bus.mem_write  = mem_write_c & reset_n;
    assign bus.reg_write  = reg_write_c & reset_n;
    assign bus.retire     = retire_c    & reset_n;
    assign bus.adr_src    = adr_src_c;
    assign bus.result_src = result_src_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_ctrl   = alu_ctrl_c;
    assign bus.imm_src    = imm_src_c;
    assign bus.illegal    = (state_q == S_TRAP);
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl.
// Reference model works per instruction class, not per state.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5;

    int         n_cyc, n_ret, n_irw, n_rw, n_mw, n_pcw, rw_idx;
    logic [3:0] alu_seen;
    logic [1:0] rs_at_ret, imm_at_dec;
    bit         adr_ok, done;
    int         path[$];
    int         ep[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] opc(input int k);
        case (k)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            default: return 7'b1101111;
        endcase
    endfunction

    // Reference ALU op from the mnemonic each funct3 names.
    function automatic logic [3:0] ref_alu(input int k, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'd0:    return (k == K_R && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd6;
            3'd2:    return 4'd5;
            3'd3:    return 4'd9;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd8 : 4'd7;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    task automatic do_reset();
        bus.mem_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_pc_write", bus.pc_write, 0);
        chk("rst_ir_write", bus.ir_write, 0);
        chk("rst_src_b", bus.alu_src_b, 2);
        chk("rst_adr_src", bus.adr_src, 0);
        @(posedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic run_instr(input int k, input logic [2:0] f3, input logic f7,
                             input logic z, input int fst, input int mst);
        int   fs, ms, st, exp_cyc, exp_pcw;
        bit   ok, wr;
        fs = 0; ms = 0;
        n_cyc = 0; n_ret = 0; n_irw = 0; n_rw = 0; n_mw = 0; n_pcw = 0;
        rw_idx = -1; alu_seen = 4'hf; rs_at_ret = 2'b11; imm_at_dec = 2'b00;
        adr_ok = 1'b1; done = 1'b0;
        path.delete();
        bus.opcode = opc(k); bus.funct3 = f3; bus.funct7b5 = f7;
        for (int c = 0; c < 64; c++) begin
            #1;
            st = int'(bus.state);
            bus.zero = (st == 9) ? z : 1'($urandom_range(0, 1));
            if (st == 0) begin
                bus.mem_ready = (fs < fst) ? 1'b0 : 1'b1;
                if (fs < fst) fs++;
            end else if (st == 3 || st == 5) begin
                bus.mem_ready = (ms < mst) ? 1'b0 : 1'b1;
                if (ms < mst) ms++;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            path.push_back(st);
            if (bus.ir_write) n_irw++;
            if (bus.pc_write) n_pcw++;
            if (bus.mem_write) n_mw++;
            if (bus.mem_write && !bus.adr_src) adr_ok = 1'b0;
            if (bus.reg_write) begin n_rw++; rw_idx = n_cyc; end
            if (st == 6 || st == 7) alu_seen = bus.alu_ctrl;
            if (st == 1) imm_at_dec = bus.imm_src;
            n_cyc++;
            if (bus.retire) begin
                n_ret++; rs_at_ret = bus.result_src; done = 1'b1;
            end
            @(posedge clk);
            if (done) break;
        end
        chk("no_timeout", done, 1);

        ep.delete();
        for (int i = 0; i <= fst; i++) ep.push_back(0);
        ep.push_back(1);
        case (k)
            K_R:  begin ep.push_back(6); ep.push_back(8); end
            K_I:  begin ep.push_back(7); ep.push_back(8); end
            K_LW: begin
                ep.push_back(2);
                for (int i = 0; i <= mst; i++) ep.push_back(3);
                ep.push_back(4);
            end
            K_SW: begin
                ep.push_back(2);
                for (int i = 0; i <= mst; i++) ep.push_back(5);
            end
            K_BR: ep.push_back(9);
            default: begin ep.push_back(10); ep.push_back(8); end
        endcase
        ok = (path.size() == ep.size());
        for (int i = 0; i < ep.size() && ok; i++)
            if (path[i] != ep[i]) ok = 1'b0;
        chk("state_path", ok, 1);

        exp_cyc = (k == K_LW) ? 5 : (k == K_BR) ? 3 : 4;
        exp_cyc += fst + ((k == K_LW || k == K_SW) ? mst : 0);
        chk("cycles", n_cyc, exp_cyc);
        chk("retire_cnt", n_ret, 1);
        chk("ir_write_cnt", n_irw, 1);
        wr = (k == K_R || k == K_I || k == K_LW || k == K_JAL);
        chk("reg_write_cnt", n_rw, wr ? 1 : 0);
        if (wr) chk("reg_write_last", rw_idx, n_cyc - 1);
        chk("mem_write_cnt", n_mw, (k == K_SW) ? mst + 1 : 0);
        chk("mem_adr_src", adr_ok, 1);
        exp_pcw = 1 + ((k == K_JAL) ? 1 : 0);
        if (k == K_BR) exp_pcw += ((f3 == 3'd0) ? z : !z) ? 1 : 0;
        chk("pc_write_cnt", n_pcw, exp_pcw);
        chk("result_src", rs_at_ret, (k == K_LW) ? 1 : 0);
        chk("imm_src", imm_at_dec,
            (k == K_SW) ? 1 : (k == K_BR) ? 2 : (k == K_JAL) ? 3 : 0);
        if (k == K_R || k == K_I) chk("alu_ctrl", alu_seen, ref_alu(k, f3, f7));
    endtask

    initial begin
        int k, fst, mst;
        logic [2:0] f3;
        bit seen;
        bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b0;
        #2;
        chk("init_state", bus.state, 0);
        chk("init_illegal", bus.illegal, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);

        run_instr(K_R, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(K_R, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr(K_I, 3'd5, 1'b1, 1'b0, 0, 0);
        run_instr(K_I, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr(K_LW, 3'd2, 1'b0, 1'b0, 2, 3);
        run_instr(K_SW, 3'd2, 1'b0, 1'b0, 0, 2);
        run_instr(K_BR, 3'd0, 1'b0, 1'b1, 0, 0);
        run_instr(K_BR, 3'd1, 1'b0, 1'b1, 0, 0);
        run_instr(K_JAL, 3'd0, 1'b0, 1'b0, 0, 0);

        bus.opcode = 7'd0; bus.mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            #1;
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.zero = 1'($urandom_range(0, 1));
            #1;
            chk("trap_state", bus.state, 11);
            chk("trap_illegal", bus.illegal, 1);
            chk("trap_strobes", {bus.pc_write, bus.ir_write, bus.mem_write,
                                 bus.reg_write, bus.retire}, 0);
            @(posedge clk);
        end
        #2;
        do_reset();

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 5);
            f3 = 3'($urandom_range(0, 7));
            if (k == K_BR) f3 = 3'($urandom_range(0, 1));
            fst = $urandom_range(0, 3);
            mst = $urandom_range(0, 3);
            run_instr(k, f3, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), fst, mst);
        end

        bus.opcode = 7'b0100011;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            bus.mem_ready = (bus.state == 4'd5) ? 1'b0 : 1'b1;
            #1;
            if (bus.state == 4'd5) seen = 1'b1;
            else @(posedge clk);
        end
        chk("sw_reached", seen, 1);
        chk("sw_mem_write", bus.mem_write, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_mem_write", bus.mem_write, 0);
        chk("abort_retire", bus.retire, 0);
        chk("abort_state", bus.state, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style main controller that sequences the team's RISC-V datapath as a multicycle machine over a shared instruction/data memory port. It decodes opcode/funct fields from the instruction register and drives every datapath select and write strobe. It stalls on a memory ready handshake and traps on unsupported encodings. Supported instructions: lw, sw, R-type ALU, I-type ALU, beq/bne, jal.

## Interface
Parameters:
- none (ALU and mux encodings fixed below)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- opcode  input  7  instruction register bits [6:0]
- funct3  input  3  instruction register bits [14:12]
- funct7b5  input  1  instruction register bit 30
- zero  input  1  ALU zero flag, same cycle
- mem_ready  input  1  memory accepted write or returned read data this cycle
- pc_write  output  1  load PC
- ir_write  output  1  load instruction register
- adr_src  output  1  memory address: 0=PC, 1=ALUOut
- mem_write  output  1  memory write request
- reg_write  output  1  register file write enable
- result_src  output  2  00=ALUOut reg, 01=Data reg, 10=ALU result
- alu_src_a  output  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  output  2  00=rs2, 01=ImmExt, 10=constant 4
- imm_src  output  2  00=I, 01=S, 10=B, 11=J
- alu_ctrl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU
- retire  output  1  one-cycle pulse on the last cycle of each instruction
- illegal  output  1  sticky trap flag
- state  output  4  current state, debug

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11. Codes 12–15 go to FETCH.
- Unlisted outputs are 0. alu_ctrl defaults to ADD.
- FETCH: adr_src=0, src_a=00, src_b=10. ir_write=pc_write=mem_ready. Holds while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE: src_a=01, src_b=01 (branch target into ALUOut). imm_src is decoded from opcode in every state: 0100011→01, 1100011→10, 1101111→11, else 00.
  - opcode 0000011/0100011→MEMADR
  - 0110011→EXECR
  - 0010011→EXECI
  - 1100011 with funct3∈{000,001}→BRANCH
  - 1101111→JAL
  - else→TRAP
- MEMADR: src_a=10, src_b=01. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1. Goes to FETCH.
- MEMWRITE: adr_src=1, mem_write=1, held until mem_ready. retire=mem_ready. Goes to FETCH on mem_ready.
- EXECR: src_a=10, src_b=00. EXECI: src_a=10, src_b=01. Both go to ALUWB.
- ALU decode (EXECR/EXECI), by funct3:
  - 000: SUB if R-type and funct7b5, else ADD
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA if funct7b5, else SRL
  - 110: OR
  - 111: AND
- ALUWB: result_src=00, reg_write=1, retire=1. Goes to FETCH.
- BRANCH: src_a=10, src_b=00, alu_ctrl=SUB, result_src=00, pc_write=zero XOR funct3[0], retire=1. Goes to FETCH.
- JAL: src_a=01, src_b=10, result_src=00, pc_write=1. Goes to ALUWB, which writes PC+4 to rd.
- TRAP: all strobes 0, illegal=1 (sticky). Remains in TRAP until reset.

## Timing
- Reset (async assert, sync deassert):
  - state=FETCH, illegal=0.
  - pc_write, ir_write, mem_write, reg_write, retire forced 0 while reset_n=0.
  - Selects show FETCH values.
- Reset mid-instruction aborts immediately. No register-file or memory write completes after reset_n falls.
- Latency with mem_ready constantly 1:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne: 3 cycles
  - jal: 4 cycles
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- pc_write, ir_write, mem_write and retire may depend combinationally on mem_ready/zero in the same cycle. All other outputs are functions of state and the IR fields only.
- retire asserts exactly once per instruction, never in TRAP.
- mem_write stays high and address selects stay stable for every stall cycle.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3), mem_ready=1:
  - states 0→1→6→8→0
  - alu_ctrl=0000 in EXECR
  - reg_write=1 only in cycle 4
  - retire once
- sub (funct7b5=1, opcode 0110011, funct3 000) → alu_ctrl=0001. srai (0010011, funct3 101, funct7b5=1) → 1000. addi with funct7b5=1 → 0000.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD:
  - 10 cycles total
  - ir_write pulses once
  - result_src=01 in MEMWB
- sw with mem_ready low 2 cycles in MEMWRITE → mem_write high 3 consecutive cycles, adr_src=1, retire only in the final cycle.
- Branches:
  - beq with zero=1 → pc_write=1 in BRANCH
  - bne with zero=1 → pc_write=0
  - jal → pc_write in JAL, then reg_write in ALUWB
- Illegal and reset cases:
  - opcode 0000000 → TRAP, illegal=1 held for 20 cycles
  - reset_n low → state 0, illegal 0
  - reset_n pulsed low during MEMWRITE → mem_write drops within the same cycle
